nor_flash_responder: RTL
========================

# nor_flash_responder

Synthesizable single-clock model of the board's 16-bit parallel NOR flash command interface, the device side of the bus our flash controllers drive (CE/WE/OE/ADDR/DATA). It decodes command writes (read array, read ID, read/clear status, block lock/unlock, block erase, word program), keeps a small block-organized array with per-block lock bits and a status register, and drives DATA back on read cycles. It lets controller designs be simulated and loop-back tested on the FPGA without the real part.

## Interface
- NB_W, 2: block index width (2^NB_W blocks)
- BLK_LSB, 16: block index = ADDR[BLK_LSB+NB_W-1:BLK_LSB]
- MEM_AW, 8: modeled words per block = 2^MEM_AW, word index = ADDR[MEM_AW-1:0]
- READ_LAT, 3: cycles of CE&OE low before DATA is driven
- ERASE_CYC, 1000: erase busy cycles, must be ≥ 2^MEM_AW
- PROG_CYC, 20: program busy cycles
- MANUF_ID, 16'h0089; DEV_ID, 16'h8961: ID words
- CLK  in  1  sole clock
- RESET  in  1  reset, synchronous, active-high
- CE  in  1  chip enable, active-low
- WE  in  1  write enable, active-low
- OE  in  1  output enable, active-low
- ADDR  in  24  word address
- DATA  inout  16  bidirectional data
- SR_OUT  out  8  status register mirror for debug/LEDs
- BUSY  out  1  erase/program in progress

## Operation
- Write cycle: every cycle with CE=0, WE=0 latches ADDR and DATA; the write commits on the first cycle after that where CE=1 or WE=1 (rising edge of the CE|WE low pulse). One commit per pulse regardless of length.
- Command state: IDLE, LOCK_SETUP, ERASE_SETUP, PROG_SETUP, BUSY_ERASE, BUSY_PROG. Read mode: ARRAY, ID, STATUS.
- IDLE commits: FF→ARRAY; 90→ID; 70→STATUS; 50→clear SR[5],SR[4],SR[1]; 60→LOCK_SETUP; 20→ERASE_SETUP; 40 or 10→PROG_SETUP; other values ignored. Only DATA[7:0] decoded.
- LOCK_SETUP: D0 clears lock bit of addressed block, 01 sets it; other → SR[5]=SR[4]=1 (sequence error). Always →IDLE, mode STATUS.
- ERASE_SETUP: D0 on unlocked block → BUSY_ERASE, SR[7]=0; D0 on locked block → SR[5]=SR[1]=1, IDLE; other → SR[5]=SR[4]=1, IDLE. Mode STATUS in all cases.
- BUSY_ERASE: writes 16'hFFFF to one word of the block per cycle (word 0 upward) and counts ERASE_CYC cycles; then SR[7]=1, IDLE.
- PROG_SETUP: next commit is data. Locked block → SR[4]=SR[1]=1, IDLE; else mem <= mem & DATA (bits only go 1→0), BUSY_PROG for PROG_CYC cycles, SR[7]=0 meanwhile. Mode STATUS.
- While BUSY: all write commits ignored; reads return SR irrespective of mode.
- Reads: ARRAY → mem word; STATUS → {8'h00,SR}; ID → word index 0: MANUF_ID, 1: DEV_ID, 2: {15'b0, lock bit of addressed block}, else 0.
- SR bits used: 7 ready, 5 erase/sequence error, 4 program/sequence error, 1 locked-block error; others 0.

## Timing
- Reset values: state IDLE, mode ARRAY, SR=8'h80, SR_OUT=8'h80, BUSY=0, all lock bits 1, DATA hi-Z, read counter 0. Array is not cleared by RESET (initialised to all FFFF at configuration only). RESET during BUSY aborts; partially erased block stays partial.
- Command commit takes effect the cycle after commit; a read starting that cycle sees the new mode.
- Read counter increments each cycle CE=0, OE=0, WE=1, saturates; cleared whenever any is inactive. DATA driven from registered read word when counter ≥ READ_LAT, otherwise hi-Z. Never driven while WE=0 (bus contention guard).
- Read word re-registered each cycle from current ADDR/mode, so address change while OE low appears 1 cycle later.
- BUSY = 1 from cycle after D0/data commit for exactly ERASE_CYC / PROG_CYC cycles; SR[7] mirrors !BUSY.

## Test plan
- After reset, write 60@020000, D0@020000, 90, read 020002 (CE/OE low 4 cycles) → DATA=0000; read 020000 → 0089; DATA hi-Z for first 3 read cycles.
- Without unlock: 20, D0 @020000, read → SR=A2; 50 then read → 80.
- Unlock block 2, 40 then 1234 @020005, wait 20 cycles, FF, read 020005 → 1234; program 00FF same word → 0034.
- Unlock, 20, D0 @020000, 70 during busy, poll → SR=00 for 1000 cycles then 80; FF, read 020005 → FFFF; block 1 words unchanged.
- 20 followed by 55 → SR=B0, state IDLE; subsequent 90 accepted.
- RESET asserted mid-erase → BUSY=0, SR=80, block 2 relocked, mode ARRAY next read.

Source files
------------

// File: rtl/nor_flash_responder.sv
// nor_flash_responder: device side of a 16-bit parallel NOR flash command bus.
// Decodes command writes, holds a small block-organised array with lock bits
// and a status register, and answers read cycles after READ_LAT cycles.
//
// state          | meaning
// ST_IDLE        | waiting for a command write
// ST_LOCK_SETUP  | 60 seen, next commit confirms lock (01) or unlock (D0)
// ST_ERASE_SETUP | 20 seen, next commit confirms block erase (D0)
// ST_PROG_SETUP  | 40/10 seen, next commit carries the program data word
// ST_BUSY_ERASE  | erasing one word per cycle, commits ignored
// ST_BUSY_PROG   | program busy time, commits ignored
module nor_flash_responder #(
    parameter int          NB_W      = 2,
    parameter int          BLK_LSB   = 16,
    parameter int          MEM_AW    = 8,
    parameter int          READ_LAT  = 3,
    parameter int          ERASE_CYC = 1000,
    parameter int          PROG_CYC  = 20,
    parameter logic [15:0] MANUF_ID  = 16'h0089,
    parameter logic [15:0] DEV_ID    = 16'h8961
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CE,
    input  logic        WE,
    input  logic        OE,
    input  logic [23:0] ADDR,
    inout  wire  [15:0] DATA,
    output logic [7:0]  SR_OUT,
    output logic        BUSY
);

    localparam int NBLK    = 1 << NB_W;
    localparam int NWORD   = 1 << MEM_AW;
    localparam int TMR_MAX = (ERASE_CYC > PROG_CYC) ? ERASE_CYC : PROG_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX);
    localparam int RC_W    = $clog2(READ_LAT + 1);
    localparam int MA_W    = NB_W + MEM_AW;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOCK_SETUP, ST_ERASE_SETUP, ST_PROG_SETUP, ST_BUSY_ERASE, ST_BUSY_PROG
    } state_t;

    typedef enum logic [1:0] {MD_ARRAY, MD_ID, MD_STATUS} mode_t;

    state_t            state_q, state_d;
    mode_t             mode_q, mode_d;
    logic [2:0]        err_q, err_d;          // {SR[5], SR[4], SR[1]}
    logic [NBLK-1:0]   lock_q, lock_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [NB_W-1:0]   ers_blk_q, ers_blk_d;
    logic [MEM_AW:0]   ers_idx_q, ers_idx_d;  // MSB set once every word is erased

    logic              wr_prev_q;
    logic [NB_W-1:0]   wr_blk_q;
    logic [MEM_AW-1:0] wr_wi_q;
    logic [15:0]       wr_data_q;

    logic [RC_W-1:0]   rd_cnt_q;
    logic [15:0]       rd_word_q, rd_word_d;

    // Array is stored inverted so the zero power-up contents of FPGA RAM read as
    // erased (FFFF); RESET never touches it.
    logic [15:0]       mem_n [NBLK*NWORD];
    logic              mem_we;
    logic [MA_W-1:0]   mem_wa;
    logic [15:0]       mem_wd_n;

    logic              wr_active, commit, busy, rd_active, unused_addr;
    logic [7:0]        cmd;
    logic [NB_W-1:0]   addr_blk;
    logic [MEM_AW-1:0] addr_wi;

    assign wr_active   = !CE && !WE;
    assign commit      = wr_prev_q && !wr_active;
    assign cmd         = wr_data_q[7:0];
    assign busy        = (state_q == ST_BUSY_ERASE) || (state_q == ST_BUSY_PROG);
    assign rd_active   = !CE && !OE && WE;
    assign addr_blk    = ADDR[BLK_LSB+NB_W-1:BLK_LSB];
    assign addr_wi     = ADDR[MEM_AW-1:0];
    assign unused_addr = ^ADDR;

    assign BUSY   = busy;
    assign SR_OUT = {!busy, 1'b0, err_q[2], err_q[1], 2'b00, err_q[0], 1'b0};
    // WE high is part of rd_active, so the part never fights a bus write.
    assign DATA   = (rd_active && rd_cnt_q == RC_W'(READ_LAT)) ? rd_word_q : 16'bz;

    // Latch address/data during the write pulse; commit fires on its trailing edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_prev_q <= 1'b0;
            wr_blk_q  <= '0;
            wr_wi_q   <= '0;
            wr_data_q <= '0;
        end else begin
            wr_prev_q <= wr_active;
            if (wr_active) begin
                wr_blk_q  <= addr_blk;
                wr_wi_q   <= addr_wi;
                wr_data_q <= DATA;
            end
        end
    end

    // Command decode, busy timers and array write requests.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        err_d     = err_q;
        lock_d    = lock_q;
        tmr_d     = tmr_q;
        ers_blk_d = ers_blk_q;
        ers_idx_d = ers_idx_q;
        mem_we    = 1'b0;
        mem_wa    = '0;
        mem_wd_n  = '0;
        case (state_q)
            ST_IDLE: begin
                if (commit) begin
                    case (cmd)
                        8'hFF:        mode_d  = MD_ARRAY;
                        8'h90:        mode_d  = MD_ID;
                        8'h70:        mode_d  = MD_STATUS;
                        8'h50:        err_d   = 3'b000;
                        8'h60:        state_d = ST_LOCK_SETUP;
                        8'h20:        state_d = ST_ERASE_SETUP;
                        8'h40, 8'h10: state_d = ST_PROG_SETUP;
                        default: ;
                    endcase
                end
            end
            ST_LOCK_SETUP: begin
                if (commit) begin
                    state_d = ST_IDLE;
                    mode_d  = MD_STATUS;
                    if (cmd == 8'hD0)      lock_d[wr_blk_q] = 1'b0;
                    else if (cmd == 8'h01) lock_d[wr_blk_q] = 1'b1;
                    else                   err_d[2:1]       = 2'b11;
                end
            end
            ST_ERASE_SETUP: begin
                if (commit) begin
                    state_d = ST_IDLE;
                    mode_d  = MD_STATUS;
                    if (cmd != 8'hD0) begin
                        err_d[2:1] = 2'b11;
                    end else if (lock_q[wr_blk_q]) begin
                        err_d[2] = 1'b1;
                        err_d[0] = 1'b1;
                    end else begin
                        state_d   = ST_BUSY_ERASE;
                        tmr_d     = TMR_W'(ERASE_CYC - 1);
                        ers_blk_d = wr_blk_q;
                        ers_idx_d = '0;
                    end
                end
            end
            ST_PROG_SETUP: begin
                if (commit) begin
                    state_d = ST_IDLE;
                    mode_d  = MD_STATUS;
                    if (lock_q[wr_blk_q]) begin
                        err_d[1] = 1'b1;
                        err_d[0] = 1'b1;
                    end else begin
                        // Programming only clears bits: OR into the inverted store.
                        mem_we   = 1'b1;
                        mem_wa   = {wr_blk_q, wr_wi_q};
                        mem_wd_n = mem_n[{wr_blk_q, wr_wi_q}] | ~wr_data_q;
                        state_d  = ST_BUSY_PROG;
                        tmr_d    = TMR_W'(PROG_CYC - 1);
                    end
                end
            end
            ST_BUSY_ERASE: begin
                if (!ers_idx_q[MEM_AW]) begin
                    mem_we    = 1'b1;
                    mem_wa    = {ers_blk_q, ers_idx_q[MEM_AW-1:0]};
                    mem_wd_n  = '0;
                    ers_idx_d = ers_idx_q + 1'b1;
                end
                if (tmr_q == '0) state_d = ST_IDLE;
                else             tmr_d   = tmr_q - 1'b1;
            end
            ST_BUSY_PROG: begin
                if (tmr_q == '0) state_d = ST_IDLE;
                else             tmr_d   = tmr_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command state registers; RESET aborts any erase/program in flight.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            mode_q    <= MD_ARRAY;
            err_q     <= '0;
            lock_q    <= '1;
            tmr_q     <= '0;
            ers_blk_q <= '0;
            ers_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            err_q     <= err_d;
            lock_q    <= lock_d;
            tmr_q     <= tmr_d;
            ers_blk_q <= ers_blk_d;
            ers_idx_q <= ers_idx_d;
        end
    end

    // Array write port.
    always_ff @(posedge CLK) begin
        if (mem_we && !RESET) mem_n[mem_wa] <= mem_wd_n;
    end

    // Read word selection: busy overrides the read mode with the status register.
    always_comb begin
        rd_word_d = 16'h0000;
        if (busy) begin
            rd_word_d = {8'h00, SR_OUT};
        end else begin
            case (mode_q)
                MD_ARRAY:  rd_word_d = ~mem_n[{addr_blk, addr_wi}];
                MD_STATUS: rd_word_d = {8'h00, SR_OUT};
                MD_ID: begin
                    if (addr_wi == MEM_AW'(0))      rd_word_d = MANUF_ID;
                    else if (addr_wi == MEM_AW'(1)) rd_word_d = DEV_ID;
                    else if (addr_wi == MEM_AW'(2)) rd_word_d = {15'b0, lock_q[addr_blk]};
                end
                default: ;
            endcase
        end
    end

    // Read latency counter and registered read word.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_cnt_q  <= '0;
            rd_word_q <= '0;
        end else begin
            if (!rd_active)                          rd_cnt_q <= '0;
            else if (rd_cnt_q != RC_W'(READ_LAT))    rd_cnt_q <= rd_cnt_q + 1'b1;
            rd_word_q <= rd_word_d;
        end
    end

endmodule
